// File: rtl/key_expansion128.sv
// AES-128 key schedule: one round key per cycle, streamed out and kept in an 11-entry store.
// Optional KEY_EXP_RESTART_EN: a start during expansion restarts it with the new key.

module aes_sbox (
   input  logic [7:0] sbox_i,
   output logic [7:0] sbox_o
);
   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // 2047 - 8*sbox_i, written as a bit pattern
   logic [10:0] msb;
   assign msb    = {~sbox_i, 3'b111};
   assign sbox_o = SBOX[msb -: 8];
endmodule

module key_expansion128 (
   input  logic         key_clk,
   input  logic         key_rst_n,
   input  logic         key_start,
   input  logic [127:0] key_in,
   output logic         key_busy,
   output logic         key_ready,
   output logic         key_out_valid,
   output logic [3:0]   key_out_round,
   output logic [127:0] key_out,
   input  logic [3:0]   key_rd_addr,
   output logic [127:0] key_rd_data
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t         state_q;
   logic           busy_q, ready_q, vld_q;
   logic [3:0]     rnd_q;
   logic [127:0]   key_q, key_d;
   logic [127:0]   store_q [11];
   logic [127:0]   rd_q;
   logic           start_ok;
   logic [31:0]    rot, sub, temp;
   logic [31:0]    w0, w1, w2, w3;
   logic [7:0]     rcon;

`ifdef KEY_EXP_RESTART_EN
   assign start_ok = key_start;
`else
   assign start_ok = key_start && (state_q != EXPAND);
`endif

   // The current round key lives in key_q; the next one is derived combinationally.
   assign rot = {key_q[23:0], key_q[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sb
      aes_sbox u_sbox (.sbox_i(rot[8*g +: 8]), .sbox_o(sub[8*g +: 8]));
   end

   always_comb begin
      rcon = 8'h00;
      case (rnd_q)
         4'd0: rcon = 8'h01;
         4'd1: rcon = 8'h02;
         4'd2: rcon = 8'h04;
         4'd3: rcon = 8'h08;
         4'd4: rcon = 8'h10;
         4'd5: rcon = 8'h20;
         4'd6: rcon = 8'h40;
         4'd7: rcon = 8'h80;
         4'd8: rcon = 8'h1b;
         4'd9: rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign temp  = sub ^ {rcon, 24'h0};
   assign w0    = key_q[127:96] ^ temp;
   assign w1    = key_q[95:64]  ^ w0;
   assign w2    = key_q[63:32]  ^ w1;
   assign w3    = key_q[31:0]   ^ w2;
   assign key_d = {w0, w1, w2, w3};

   always_ff @(posedge key_clk or negedge key_rst_n) begin
      if (!key_rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         vld_q   <= 1'b0;
         rnd_q   <= 4'd0;
         key_q   <= '0;
      end else if (start_ok) begin
         state_q <= EXPAND;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
         vld_q   <= 1'b1;
         rnd_q   <= 4'd0;
         key_q   <= key_in;
      end else if (state_q == EXPAND) begin
         if (rnd_q == 4'd10) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            vld_q   <= 1'b0;
         end else begin
            vld_q   <= 1'b1;
            rnd_q   <= rnd_q + 4'd1;
            key_q   <= key_d;
         end
      end else begin
         vld_q <= 1'b0;
      end
   end

   // Store is written from the streamed register, so an entry trails its strobe by one cycle.
   always_ff @(posedge key_clk or negedge key_rst_n) begin
      if (!key_rst_n) begin
         for (int i = 0; i < 11; i++) store_q[i] <= '0;
         rd_q <= '0;
      end else begin
         rd_q <= '0;
         for (int i = 0; i < 11; i++) begin
            if (vld_q && rnd_q == 4'(i)) store_q[i] <= key_q;
            if (key_rd_addr == 4'(i))    rd_q       <= store_q[i];
         end
      end
   end

   assign key_busy      = busy_q;
   assign key_ready     = ready_q;
   assign key_out_valid = vld_q;
   assign key_out_round = rnd_q;
   assign key_out       = key_q;
   assign key_rd_data   = rd_q;
endmodule

// File: doc/key_expansion128.md
# key_expansion128

AES-128 key-schedule unit producing the eleven 128-bit round keys consumed by the round pipeline as `round_keyin`. Upstream neighbour of each round-transform stage: it expands a cipher key one round per cycle, streams each key as it is produced, and keeps all eleven in a local store behind a registered random-access read port. This lets every pipelined round stage fetch its key by round index.

## Interface

Parameters: none.

Ports:
- key_clk  in  1  clock; all state updates on rising edge
- key_rst_n  in  1  reset, asynchronous, active-low
- key_start  in  1  single-cycle request to expand `key_in`
- key_in  in  128  cipher key; w0 = [127:96], w3 = [31:0]; sampled on accepted start
- key_busy  out  1  high while expansion is in progress
- key_ready  out  1  high when all 11 stored keys belong to the last accepted key
- key_out_valid  out  1  one-cycle strobe per generated round key
- key_out_round  out  4  round index 0..10 of `key_out`
- key_out  out  128  generated round key, registered
- key_rd_addr  in  4  read index 0..10
- key_rd_data  out  128  stored key at `key_rd_addr`, registered, 1-cycle latency

## Operation

- FSM states: IDLE, EXPAND, DONE.
  - Reset enters IDLE.
  - IDLE or DONE + key_start → EXPAND.
  - EXPAND with round counter = 10 → DONE.
- Start accepted in IDLE or DONE. On acceptance:
  - key_ready clears.
  - key_in is latched as round key 0.
  - The round counter is set to 0.
- Each EXPAND cycle produces round r from round r−1, w3 = last word of r−1:
  - temp = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- SubWord uses four combinational instances of the forward AES S-box local to this block. There is no pipeline register inside the recurrence.
- Each generated key is written to store entry r. The same key is presented on key_out / key_out_round with key_out_valid high for one cycle.
- Read port:
  - key_rd_data <= store[key_rd_addr] every cycle, independent of FSM state.
  - Addresses 11..15 return 0.
  - During EXPAND, entries not yet rewritten return the previous key's values.
- key_start while in EXPAND: handling is set by the macro under Configuration.

## Timing

- Reset values: key_busy = 0, key_ready = 0, key_out_valid = 0, key_out_round = 0, key_out = 0, key_rd_data = 0. All 11 store entries = 0; FSM in IDLE.
- Start accepted at edge T:
  - key_out_valid high in cycles T+1 .. T+11, carrying rounds 0..10 in order, one per cycle, no gaps.
  - key_busy high in cycles T+1 .. T+11.
  - key_ready rises at T+12 and holds until the next accepted start or reset.
- Store entry r is readable on key_rd_data two cycles after its key_out_valid strobe: one cycle for the write, then one cycle of read latency.
- Start in DONE: behaves exactly as from IDLE; key_ready drops in the cycle after the start.
- Reset asserted mid-expansion: all outputs and store entries clear immediately (asynchronous); FSM returns to IDLE; the partial expansion is discarded.

## Configuration

- Macro `KEY_EXP_RESTART_EN`.
- Defined: key_start during EXPAND is accepted.
  - key_in is re-latched and the round counter restarts at 0.
  - The next cycle emits round 0 of the new key.
  - The full 11-strobe sequence follows; key_busy stays high throughout.
- Undefined: key_start during EXPAND is ignored. The current expansion completes unchanged, and no queued start is kept.

## Test plan

- FIPS-197 A.1, expansion: key_in = 2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Round 0 on key_out is key_in.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - key_ready rises at T+12.
- Read-back: after the A.1 expansion, sweep key_rd_addr 0..15.
  - key_rd_data matches the streamed keys one cycle later.
  - Addresses 11..15 read 0.
- All-zero key: key_in = 0. Round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back: start the A.1 key, then start the zero key in the DONE cycle.
  - key_ready drops.
  - Store entry 10 reads the zero-key round 10 after completion.
- Busy start: start at T, second start with a different key at T+5.
  - With `KEY_EXP_RESTART_EN`: round 0 of the new key is emitted at T+6, followed by 11 strobes total.
  - Without it: the original sequence completes unchanged.
- Async reset: assert key_rst_n low at T+6 of an expansion.
  - All outputs read 0 in the same cycle.
  - Store reads 0.
  - After release, key_ready stays 0 until a new start.
